mux_4x1_rr_arbiter: RTL and testbench

MUX_4X1_RR_ARBITER -- requirements
Module: mux_4x1_rr_arbiter

---
 rtl/mux_4x1_rr_arbiter_if.sv | 26 ++
 rtl/mux_4x1_rr_arbiter.sv | 96 +++++++++
 tb/tb_mux_4x1_rr_arbiter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mux_4x1_rr_arbiter_if.sv
// Bus bundle for the 4-to-1 round-robin arbiter: four input channels plus one registered output stream.
// The master side drives the channels and the downstream ready. The slave side is the arbiter.
interface mux_4x1_rr_arbiter_if #(
    parameter int WIDTH = 8
);
    logic [4*WIDTH-1:0] in_data;
    logic [3:0]         in_valid;
    logic [3:0]         in_last;
    logic [3:0]         in_ready;
    logic [WIDTH-1:0]   dout;
    logic               vout;
    logic               lout;
    logic               rdyin;
    logic               s0;
    logic               s1;

    modport master (
        output in_data, in_valid, in_last, rdyin,
        input  in_ready, dout, vout, lout, s0, s1
    );

    modport slave (
        input  in_data, in_valid, in_last, rdyin,
        output in_ready, dout, vout, lout, s0, s1
    );
endinterface

// File: rtl/mux_4x1_rr_arbiter.sv
// 4-to-1 round-robin arbiter with a burst lock and a registered output stage.
// {s0,s1} carries the source channel index in the same encoding a 1x4 demux select uses.
module mux_4x1_rr_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    mux_4x1_rr_arbiter_if.slave   bus
);

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] ptr, ptr_nxt;
    logic [1:0] lch, lch_nxt;
    logic [1:0] g;
    logic [1:0] idx;
    logic       found;
    logic       load;
    logic       take;

    assign load = !bus.vout || bus.rdyin;

    // Grant selection. In LOCK only the held channel may be served.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        g     = ptr;
        idx   = ptr;
        found = 1'b0;
        if (state == LOCK) begin
            g     = lch;
            found = bus.in_valid[lch];
        end else begin
            for (int i = 0; i < 4; i++) begin
                idx = ptr + 2'(i);
                if (!found && bus.in_valid[idx]) begin
                    g     = idx;
                    found = 1'b1;
                end
            end
        end
    end

    assign take         = load && found && !rst;
    assign bus.in_ready = take ? (4'b0001 << g) : 4'b0000;

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        lch_nxt   = lch;
        if (take) begin
            if (state == ARB) begin
                ptr_nxt = g + 2'd1;
                if (!bus.in_last[g]) begin
                    state_nxt = LOCK;
                    lch_nxt   = g;
                end
            end else if (bus.in_last[lch]) begin
                state_nxt = ARB;
                ptr_nxt   = lch + 2'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ARB;
            ptr      <= 2'd0;
            lch      <= 2'd0;
            bus.dout <= '0;
            bus.s0   <= 1'b0;
            bus.s1   <= 1'b0;
            bus.lout <= 1'b0;
            bus.vout <= 1'b0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            lch   <= lch_nxt;
            if (load) begin
                // An empty load slot drains vout. The payload registers keep their last word.
                bus.vout <= found;
                if (found) begin
                    bus.dout <= bus.in_data[int'(g)*WIDTH +: WIDTH];
                    bus.s0   <= g[1];
                    bus.s1   <= g[0];
                    bus.lout <= bus.in_last[g];
                end
            end
        end
    end

endmodule

// File: tb/tb_mux_4x1_rr_arbiter.sv
// Directed test for mux_4x1_rr_arbiter covering round-robin order, burst lock, backpressure,
// pointer wrap, lock stall and reset. All expected values are computed by hand.
module tb_mux_4x1_rr_arbiter;

    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    mux_4x1_rr_arbiter_if #(.WIDTH(WIDTH)) bus ();

    mux_4x1_rr_arbiter #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rdy(input string tag, input logic [3:0] r);
        #1;
        check({tag, ".in_ready"}, 32'(bus.in_ready), 32'(r));
    endtask

    task automatic expect_out(input string tag, input logic [7:0] d, input logic [1:0] s,
                              input logic l, input logic v);
        check({tag, ".dout"}, 32'(bus.dout), 32'(d));
        check({tag, ".sel"},  32'({bus.s0, bus.s1}), 32'(s));
        check({tag, ".lout"}, 32'(bus.lout), 32'(l));
        check({tag, ".vout"}, 32'(bus.vout), 32'(v));
    endtask

    task automatic set_data(input logic [7:0] base);
        for (int n = 0; n < 4; n++) bus.in_data[n*WIDTH +: WIDTH] = base + 8'(n);
    endtask

    task automatic set_ch(input int c, input logic [7:0] val);
        bus.in_data[c*WIDTH +: WIDTH] = val;
    endtask

    initial begin
        rst          = 1'b1;
        bus.rdyin    = 1'b1;
        bus.in_valid = 4'hF;
        bus.in_last  = 4'hF;
        set_data(8'h10);

        // Reset: no channel is granted while rst is high.
        tick();
        expect_rdy("rst_hold", 4'b0000);
        tick();
        rst = 1'b0;
        expect_out("reset", 8'h00, 2'd0, 1'b0, 1'b0);

        // All four channels valid: grants rotate 0,1,2,3,0.
        for (int k = 0; k < 5; k++) begin
            expect_rdy($sformatf("rr%0d", k), 4'b0001 << (k % 4));
            tick();
            expect_out($sformatf("rr%0d", k), 8'h10 + 8'(k % 4), 2'(k % 4), 1'b1, 1'b1);
        end
        bus.in_valid = 4'b0000;
        expect_rdy("idle", 4'b0000);
        tick();
        expect_out("idle", 8'h10, 2'd0, 1'b1, 1'b0);

        // Channel 2 bursts while 0 and 3 wait. ptr=1, so channel 2 wins first.
        set_data(8'h20);
        set_ch(2, 8'hB1);
        bus.in_valid = 4'b1101;
        bus.in_last  = 4'b1011;
        expect_rdy("burst1", 4'b0100);
        tick();
        expect_out("burst1", 8'hB1, 2'd2, 1'b0, 1'b1);
        set_ch(2, 8'hB2);
        expect_rdy("burst2", 4'b0100);
        tick();
        expect_out("burst2", 8'hB2, 2'd2, 1'b0, 1'b1);
        set_ch(2, 8'hB3);
        bus.in_last = 4'b1111;
        expect_rdy("burst3", 4'b0100);
        tick();
        expect_out("burst3", 8'hB3, 2'd2, 1'b1, 1'b1);
        bus.in_valid = 4'b1001;
        expect_rdy("after3", 4'b1000);
        tick();
        expect_out("after3", 8'h23, 2'd3, 1'b1, 1'b1);
        expect_rdy("after0", 4'b0001);
        tick();
        expect_out("after0", 8'h20, 2'd0, 1'b1, 1'b1);

        // Backpressure: 0xA5 held for 5 cycles with rdyin=0.
        set_data(8'h30);
        set_ch(1, 8'hA5);
        bus.in_valid = 4'b0010;
        expect_rdy("load_a5", 4'b0010);
        tick();
        expect_out("load_a5", 8'hA5, 2'd1, 1'b1, 1'b1);
        bus.rdyin    = 1'b0;
        bus.in_valid = 4'hF;
        set_data(8'h30);
        for (int k = 0; k < 5; k++) begin
            expect_rdy($sformatf("stall%0d", k), 4'b0000);
            tick();
            expect_out($sformatf("stall%0d", k), 8'hA5, 2'd1, 1'b1, 1'b1);
        end
        bus.rdyin = 1'b1;
        expect_rdy("unstall", 4'b0100);
        tick();
        expect_out("unstall", 8'h32, 2'd2, 1'b1, 1'b1);

        // ptr=3 with only channel 3 valid, then the pointer wraps to 0.
        bus.in_valid = 4'b1000;
        expect_rdy("wrap3", 4'b1000);
        tick();
        expect_out("wrap3", 8'h33, 2'd3, 1'b1, 1'b1);
        bus.in_valid = 4'hF;
        expect_rdy("wrap0", 4'b0001);

        // Lock on channel 1. Channel 1 goes idle and channel 0 must stay unserved.
        set_data(8'h40);
        bus.in_valid = 4'b0010;
        bus.in_last  = 4'b1101;
        expect_rdy("lock1", 4'b0010);
        tick();
        expect_out("lock1", 8'h41, 2'd1, 1'b0, 1'b1);
        bus.in_valid = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            expect_rdy($sformatf("lockgap%0d", k), 4'b0000);
            tick();
            expect_out($sformatf("lockgap%0d", k), 8'h41, 2'd1, 1'b0, 1'b0);
        end
        set_ch(1, 8'h42);
        bus.in_valid = 4'b0011;
        bus.in_last  = 4'hF;
        expect_rdy("lockend", 4'b0010);
        tick();
        expect_out("lockend", 8'h42, 2'd1, 1'b1, 1'b1);
        bus.in_valid = 4'b0001;
        expect_rdy("served0", 4'b0001);
        tick();
        expect_out("served0", 8'h40, 2'd0, 1'b1, 1'b1);

        // Reset in the middle of a channel 3 burst, with a capture pending on the same edge.
        set_data(8'h50);
        bus.in_valid = 4'b1000;
        bus.in_last  = 4'b0111;
        expect_rdy("b3w1", 4'b1000);
        tick();
        expect_out("b3w1", 8'h53, 2'd3, 1'b0, 1'b1);
        set_ch(3, 8'h54);
        expect_rdy("b3w2", 4'b1000);
        tick();
        expect_out("b3w2", 8'h54, 2'd3, 1'b0, 1'b1);
        rst          = 1'b1;
        bus.in_valid = 4'b1001;
        expect_rdy("rst_mid", 4'b0000);
        tick();
        expect_out("rst_mid", 8'h00, 2'd0, 1'b0, 1'b0);
        rst         = 1'b0;
        bus.in_last = 4'hF;
        expect_rdy("post_rst", 4'b0001);
        tick();
        expect_out("post_rst", 8'h50, 2'd0, 1'b1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
